// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: opcodes, FSM states and
// instruction field positions of the fixed 16-bit encoding.
package control_sequencer_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ALU  = 4'h1;
   localparam logic [3:0] OP_MOVI = 4'h2;
   localparam logic [3:0] OP_JMP  = 4'h3;
   localparam logic [3:0] OP_JZ   = 4'h4;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam int unsigned OP_MSB    = 15;
   localparam int unsigned OP_LSB    = 12;
   localparam int unsigned RD_MSB    = 11;
   localparam int unsigned RD_LSB    = 9;
   localparam int unsigned RA_MSB    = 8;
   localparam int unsigned RA_LSB    = 6;
   localparam int unsigned RB_MSB    = 5;
   localparam int unsigned RB_LSB    = 3;
   localparam int unsigned ALUOP_MSB = 2;
   localparam int unsigned ALUOP_LSB = 0;
   localparam int unsigned IMM_MSB   = 7;
   localparam int unsigned IMM_LSB   = 0;

   localparam int unsigned ZERO_FLAG_BIT = 0;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StExec,
      StWb,
      StHalt
   } state_e;

   function automatic logic op_is_defined(logic [3:0] op);
      return (op == OP_NOP) || (op == OP_ALU) || (op == OP_MOVI) ||
             (op == OP_JMP) || (op == OP_JZ)  || (op == OP_HALT);
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and the
// instruction memory (slave).
interface control_sequencer_if #(
   parameter int unsigned AW = 8,
   parameter int unsigned IW = 16
);
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_valid;
   logic [IW-1:0] imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_valid,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_valid,
      output imem_data
   );
endinterface

// File: rtl/control_sequencer.sv
// Fetch/execute control stage: fetches instruction words, decodes them and
// drives the register/ALU datapath strobes; owns pc, ir and the zero flag.
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int unsigned AW = 8,
   parameter int unsigned IW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   control_sequencer_if.master  imem,
   input  logic [7:0]           flags,
   output logic [2:0]           alu_op,
   output logic [2:0]           ri_a,
   output logic [2:0]           ri_b,
   output logic [2:0]           ri_d,
   output logic [7:0]           wd,
   output logic                 rw,
   output logic                 wen,
   output logic                 halted,
   output logic                 illegal
);

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [IW-1:0] ir_q, ir_d;
   logic          z_q, z_d;
   logic          illegal_q, illegal_d;

   logic [3:0]    op;
   logic [7:0]    imm8;
   logic          dec_rw, dec_wen, dec_alu, dec_halt, dec_illegal, dec_jump;
   logic [AW-1:0] pc_inc, pc_tgt;

   // Only the zero flag is consumed here.
   logic unused_flags;
   assign unused_flags = ^flags[7:1];

   always_comb begin
      op          = ir_q[OP_MSB:OP_LSB];
      imm8        = ir_q[IMM_MSB:IMM_LSB];
      dec_rw      = 1'b0;
      dec_wen     = 1'b0;
      dec_alu     = 1'b0;
      dec_halt    = 1'b0;
      dec_jump    = 1'b0;
      dec_illegal = !op_is_defined(op);
      case (op)
         OP_ALU: begin
            dec_alu = 1'b1;
            dec_rw  = 1'b1;
         end
         OP_MOVI: begin
            dec_rw  = 1'b1;
            dec_wen = 1'b1;
         end
         OP_JMP:  dec_jump = 1'b1;
         OP_JZ:   dec_jump = z_q;
         OP_HALT: dec_halt = 1'b1;
         default: ;
      endcase
   end

   assign pc_inc = pc_q + AW'(1);
   assign pc_tgt = AW'(imm8);

   // Operand fields follow ir in every state so the datapath inputs stay settled.
   assign alu_op = ir_q[ALUOP_MSB:ALUOP_LSB];
   assign ri_a   = ir_q[RA_MSB:RA_LSB];
   assign ri_b   = ir_q[RB_MSB:RB_LSB];
   assign ri_d   = ir_q[RD_MSB:RD_LSB];
   assign wd     = imm8;

   assign imem.imem_addr = pc_q;
   assign halted         = (state_q == StHalt);
   assign illegal        = illegal_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ir_d          = ir_q;
      z_d           = z_q;
      illegal_d     = illegal_q;
      imem.imem_req = 1'b0;
      rw            = 1'b0;
      wen           = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StFetch;
               pc_d    = '0;
            end
         end
         StFetch: begin
            imem.imem_req = 1'b1;
            if (imem.imem_valid) begin
               ir_d    = imem.imem_data;
               state_d = StExec;
            end
         end
         StExec: begin
            rw  = dec_rw;
            wen = dec_wen;
            if (dec_alu) begin
               z_d = flags[ZERO_FLAG_BIT];
            end
            if (dec_illegal) begin
               illegal_d = 1'b1;
            end
            state_d = dec_halt ? StHalt : StWb;
         end
         StWb: begin
            pc_d    = dec_jump ? pc_tgt : pc_inc;
            state_d = StFetch;
         end
         StHalt: begin
            if (start) begin
               state_d   = StFetch;
               pc_d      = '0;
               illegal_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         pc_q      <= '0;
         ir_q      <= '0;
         z_q       <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         z_q       <= z_d;
         illegal_q <= illegal_d;
      end
   end

endmodule
